// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-fetch request sequencer: issues word-aligned bus requests, tags responses for the
// fetch FIFO and drops stale responses after a branch. Optional PCC bounds check: FETCH_PCC_CHECK_EN.
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_OUTSTANDING = 2,
  parameter int unsigned EXC_W           = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic               branch_i,
  input  logic [31:0]        branch_addr_i,
  output logic               busy_o,
  output logic               instr_req_o,
  output logic [31:0]        instr_addr_o,
  input  logic               instr_gnt_i,
  input  logic               instr_rvalid_i,
  input  logic [31:0]        instr_rdata_i,
  input  logic               instr_err_i,
  output logic               fifo_clear_o,
  output logic               fifo_in_valid_o,
  output logic [31:0]        fifo_in_addr_o,
  output logic [31:0]        fifo_in_rdata_o,
  output logic [2*EXC_W-1:0] fifo_in_exc_o,
`ifdef FETCH_PCC_CHECK_EN
  input  logic [31:0]        pcc_base_i,
  input  logic [31:0]        pcc_top_i,
`endif
  input  logic               fifo_in_ready_i
);

  localparam int unsigned     PtrW    = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;
  localparam logic [2:0]      MaxOut  = 3'(NUM_OUTSTANDING);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(NUM_OUTSTANDING - 1);

  typedef enum logic [1:0] {StIdle, StReq, StStall} state_e;

  state_e          state_q, state_d, idle_next;
  logic [1:0]      out_q, out_d, out_nb;
  logic [1:0]      disc_q, disc_d, disc_nb;
  logic [2:0]      total_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic            half_q, half_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]     addr_q [NUM_OUTSTANDING];
  logic [31:0]     req_addr;
  logic            gnt_fire, rsp_take, rsp_discard, push_rsp, q_push, can_issue;
  logic            pcc_fault, fault_push, stopped, busy_extra;
  logic [31:0]     fault_addr;
  logic [EXC_W-1:0] exc_half;
  logic            unused_branch_lsb;

  assign unused_branch_lsb = branch_addr_i[0];

  // Push address keeps the halfword offset of a branch target for the first fetch only.
  assign req_addr    = {fetch_addr_q[31:2], half_q, 1'b0};
  assign instr_req_o = (state_q == StReq) & ~pcc_fault;
  assign instr_addr_o = fetch_addr_q;

  assign gnt_fire    = instr_req_o & instr_gnt_i;
  assign rsp_discard = instr_rvalid_i & (disc_q != 2'd0);
  assign rsp_take    = instr_rvalid_i & (disc_q == 2'd0) & (out_q != 2'd0);
  assign push_rsp    = rsp_take & ~branch_i;
  assign q_push      = gnt_fire & ~branch_i;

`ifdef FETCH_PCC_CHECK_EN
  logic        stop_q, stop_d, fpend_q, fpend_d;
  logic [31:0] faddr_q, faddr_d;

  assign pcc_fault  = (state_q == StReq) &
                      ((fetch_addr_q < pcc_base_i) |
                       (({1'b0, fetch_addr_q} + 33'd4) > {1'b0, pcc_top_i}));
  assign fault_push = fpend_q & (out_q == 2'd0) & ~branch_i;
  assign stopped    = stop_d;
  assign busy_extra = fpend_q;
  assign fault_addr = faddr_q;

  always_comb begin
    stop_d  = stop_q;
    fpend_d = fpend_q;
    faddr_d = faddr_q;
    if (branch_i) begin
      stop_d  = 1'b0;
      fpend_d = 1'b0;
    end else begin
      if (pcc_fault) begin
        stop_d  = 1'b1;
        fpend_d = 1'b1;
        faddr_d = req_addr;
      end
      if (fault_push) fpend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stop_q  <= 1'b0;
      fpend_q <= 1'b0;
      faddr_q <= '0;
    end else begin
      stop_q  <= stop_d;
      fpend_q <= fpend_d;
      faddr_q <= faddr_d;
    end
  end
`else
  assign pcc_fault  = 1'b0;
  assign fault_push = 1'b0;
  assign stopped    = 1'b0;
  assign busy_extra = 1'b0;
  assign fault_addr = '0;
`endif

  always_comb begin
    out_nb  = out_q + {1'b0, gnt_fire} - {1'b0, rsp_take};
    disc_nb = disc_q - {1'b0, rsp_discard};
    out_d   = out_nb;
    disc_d  = disc_nb;
    if (branch_i) begin
      // Everything still in flight becomes stale, including a grant taken this cycle.
      out_d  = 2'd0;
      disc_d = disc_nb + out_nb;
    end
    total_d   = {1'b0, out_d} + {1'b0, disc_d};
    can_issue = req_i & fifo_in_ready_i & ~stopped & (total_d < MaxOut);
    idle_next = can_issue ? StReq : (req_i ? StStall : StIdle);

    state_d = state_q;
    if (branch_i) begin
      state_d = idle_next;
    end else begin
      unique case (state_q)
        StIdle, StStall: state_d = idle_next;
        StReq: begin
          if (pcc_fault)     state_d = StStall;
          else if (gnt_fire) state_d = idle_next;
        end
        default: state_d = StIdle;
      endcase
    end

    fetch_addr_d = fetch_addr_q;
    half_d       = half_q;
    if (branch_i) begin
      fetch_addr_d = {branch_addr_i[31:2], 2'b00};
      half_d       = branch_addr_i[1];
    end else if (gnt_fire) begin
      fetch_addr_d = fetch_addr_q + 32'd4;
      half_d       = 1'b0;
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (branch_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (q_push)   wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (push_rsp) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      out_q        <= 2'd0;
      disc_q       <= 2'd0;
      fetch_addr_q <= '0;
      half_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < NUM_OUTSTANDING; i++) addr_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      fetch_addr_q <= fetch_addr_d;
      half_q       <= half_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      if (q_push) addr_q[wr_ptr_q] <= req_addr;
    end
  end

  always_comb begin
    exc_half    = '0;
    exc_half[0] = push_rsp & instr_err_i;
    exc_half[1] = fault_push;
  end

  assign fifo_clear_o    = branch_i;
  assign fifo_in_valid_o = push_rsp | fault_push;
  assign fifo_in_addr_o  = fault_push ? fault_addr : addr_q[rd_ptr_q];
  assign fifo_in_rdata_o = fault_push ? 32'd0 : instr_rdata_i;
  assign fifo_in_exc_o   = {exc_half, exc_half};
  assign busy_o = instr_req_o | (out_q != 2'd0) | (disc_q != 2'd0) | busy_extra;

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Scoreboard bench for ibex_fetch_req_ctrl: a bus responder, a transaction model that predicts
// bus addresses and FIFO pushes, and directed phases (streaming, stall, branch, reset, wrap/PCC).
module tb_ibex_fetch_req_ctrl;
  localparam int unsigned N     = 2;
  localparam int unsigned EXC_W = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i, req_i, branch_i, instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] branch_addr_i, instr_rdata_i;
  logic        busy_o, instr_req_o, fifo_clear_o, fifo_in_valid_o, fifo_in_ready_i;
  logic [31:0] instr_addr_o, fifo_in_addr_o, fifo_in_rdata_o;
  logic [7:0]  fifo_in_exc_o;
  logic [31:0] pcc_base_i, pcc_top_i;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        rsp_en;
  logic [31:0] err_addr;
  logic [31:0] rsp_q[$];
  exp_t        exp_q[$];
  logic [31:0] m_ptr = '0;
  logic        m_half = 1'b0;
  int          bus_out = 0;

  always #5 clk = ~clk;

  ibex_fetch_req_ctrl #(.NUM_OUTSTANDING(N), .EXC_W(EXC_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .busy_o         (busy_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_in_valid_o(fifo_in_valid_o),
    .fifo_in_addr_o (fifo_in_addr_o),
    .fifo_in_rdata_o(fifo_in_rdata_o),
    .fifo_in_exc_o  (fifo_in_exc_o),
`ifdef FETCH_PCC_CHECK_EN
    .pcc_base_i     (pcc_base_i),
    .pcc_top_i      (pcc_top_i),
`endif
    .fifo_in_ready_i(fifo_in_ready_i)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0013 | (a << 8);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60 && busy_o; i++) @(negedge clk);
    @(negedge clk);
    check({name, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({name, "_left"}, exp_q.size(), 32'd0);
  endtask

  // Memory-like responder: answers grants in order, one cycle later at the earliest.
  initial begin
    instr_gnt_i    = 1'b1;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    instr_err_i    = 1'b0;
    forever begin
      @(negedge clk);
      if (instr_rvalid_i) rsp_q.delete(0);
      if (instr_req_o && instr_gnt_i) rsp_q.push_back(instr_addr_o);
      @(posedge clk);
      #2;
      if (rsp_en && rsp_q.size() != 0) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_word(rsp_q[0]);
        instr_err_i    = (rsp_q[0] == err_addr);
      end else begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        instr_err_i    = 1'b0;
      end
    end
  end

  // Monitor: predicts each bus address and the push it must produce, then compares pushes.
  always @(negedge clk) begin : monitor
    logic grant;
    exp_t e;
    grant = instr_req_o & instr_gnt_i;
    if (rst_i) begin
      exp_q.delete();
      m_ptr  = '0;
      m_half = 1'b0;
    end else begin
      if (branch_i) begin
        check("branch_clear", {31'd0, fifo_clear_o}, 32'd1);
        check("branch_no_push", {31'd0, fifo_in_valid_o}, 32'd0);
      end else if (fifo_in_valid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_push: got addr %h data %h, expected no push", fifo_in_addr_o,
                   fifo_in_rdata_o);
        end else begin
          e = exp_q.pop_front();
          check("push_addr", fifo_in_addr_o, e.addr);
          check("push_data", fifo_in_rdata_o, e.data);
          check("push_exc", {24'd0, fifo_in_exc_o}, {24'd0, e.exc});
        end
      end
      if (grant) begin
        check("bus_addr", instr_addr_o, m_ptr);
        if (!branch_i) begin
          e.addr = {m_ptr[31:2], m_half, 1'b0};
          e.data = mem_word(m_ptr);
          e.exc  = (m_ptr == err_addr) ? 8'h11 : 8'h00;
          exp_q.push_back(e);
        end
        m_ptr  = m_ptr + 32'd4;
        m_half = 1'b0;
      end
      if (branch_i) begin
        exp_q.delete();
        m_ptr  = {branch_addr_i[31:2], 2'b00};
        m_half = branch_addr_i[1];
      end
    end
    bus_out = bus_out + int'(grant) - int'(instr_rvalid_i);
    if (grant) begin
      n_cmp++;
      if (bus_out > N) begin
        n_err++;
        $display("FAIL inflight_bound: got %0d in flight, limit %0d", bus_out, N);
      end
    end
  end

  initial begin
    exp_t f;
    int   reqs;
    rst_i           = 1'b1;
    req_i           = 1'b0;
    branch_i        = 1'b0;
    branch_addr_i   = '0;
    fifo_in_ready_i = 1'b1;
    rsp_en          = 1'b0;
    err_addr        = 32'h20;
    pcc_base_i      = 32'h0;
    pcc_top_i       = 32'hFFFF_FFFF;
    step(3);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_req", {31'd0, instr_req_o}, 32'd0);
    check("rst_addr", instr_addr_o, 32'd0);
    check("rst_valid", {31'd0, fifo_in_valid_o}, 32'd0);
    check("rst_clear", {31'd0, fifo_clear_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);

    // Back-to-back streaming from 0x0 with an error response at 0x20.
    step(1); rsp_en = 1'b1; req_i = 1'b1;
    step(14); req_i = 1'b0;
    wait_idle("stream");

    // Fill outstanding slots, then hold off on FIFO readiness.
    step(1); rsp_en = 1'b0; req_i = 1'b1;
    step(5); @(negedge clk);
    check("stall_full_req", {31'd0, instr_req_o}, 32'd0);
    check("stall_full_busy", {31'd0, busy_o}, 32'd1);
    step(1); fifo_in_ready_i = 1'b0; rsp_en = 1'b1;
    step(5); @(negedge clk);
    check("stall_notready_req", {31'd0, instr_req_o}, 32'd0);
    check("stall_drained", exp_q.size(), 32'd0);
    step(1); fifo_in_ready_i = 1'b1;
    step(6); req_i = 1'b0;
    wait_idle("resume");

    // Branch to 0x102 with two requests in flight.
    step(1); rsp_en = 1'b0; req_i = 1'b1;
    step(5); branch_i = 1'b1; branch_addr_i = 32'h102;
    step(1); branch_i = 1'b0;
    step(2); @(negedge clk);
    check("discard_stall_req", {31'd0, instr_req_o}, 32'd0);
    check("discard_busy", {31'd0, busy_o}, 32'd1);
    step(1); rsp_en = 1'b1;
    step(8); req_i = 1'b0;
    wait_idle("branch");

    // Reset with requests in flight; their late responses must be ignored.
    step(1); rsp_en = 1'b0; req_i = 1'b1;
    step(5); req_i = 1'b0; rst_i = 1'b1;
    step(1); rst_i = 1'b0;
    @(negedge clk);
    check("rstmid_busy", {31'd0, busy_o}, 32'd0);
    check("rstmid_addr", instr_addr_o, 32'd0);
    step(1); rsp_en = 1'b1;
    step(4); @(negedge clk);
    check("stale_busy", {31'd0, busy_o}, 32'd0);

`ifndef FETCH_PCC_CHECK_EN
    // Address wrap past 0xFFFFFFFC.
    step(1); req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFF8;
    step(1); branch_i = 1'b0;
    step(6); req_i = 1'b0;
    wait_idle("wrap");
`else
    // Bounds fault at 0x10: pushed after the two legal fetches, then fetching stops.
    step(1); pcc_top_i = 32'h10; rsp_en = 1'b0; req_i = 1'b1;
    branch_i = 1'b1; branch_addr_i = 32'h8;
    step(1); branch_i = 1'b0;
    step(4);
    f.addr = 32'h10; f.data = 32'h0; f.exc = 8'h22;
    exp_q.push_back(f);
    rsp_en = 1'b1;
    step(4);
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      reqs += int'(instr_req_o);
    end
    check("pcc_no_req", reqs, 32'd0);
    check("pcc_pushed", exp_q.size(), 32'd0);
    step(1); req_i = 1'b0; branch_i = 1'b1; branch_addr_i = 32'h0;
    step(1); branch_i = 1'b0;
    wait_idle("pcc");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
